// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the asynchronous FIFO pointer logic.
//               Holds the default address width and the Gray-code helper
//               functions that both the write and read sides use.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default memory address width; the FIFO depth is 2**FIFO_ADDR_SIZE.
  localparam int FIFO_ADDR_SIZE = 4;

  // Widest pointer the helper functions handle.
  localparam int MAX_PTR_W = 32;

  // Binary to Gray. A zero-extended operand of any width up to MAX_PTR_W
  // yields its zero-extended Gray code, so one function serves every width.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary by XOR prefix from the MSB down. The bits above the real
  // width are zero, so they do not disturb the result.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
    logic [MAX_PTR_W-1:0] bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary converter (XOR prefix chain).
// Ports       : gray  in  W  Gray-coded value
//               bin   out W  binary equivalent
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin[W-1] = gray[W-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < W - 1; i++) begin : g_bit
    assign bin[i] = bin[i+1] ^ gray[i];
  end

endmodule
`default_nettype wire

// File: rtl/wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full
// Description : Write-side pointer and full-flag controller for the async
//               FIFO. Keeps the binary write pointer (memory address) and the
//               Gray write pointer sent to the read domain, and produces a
//               registered full flag, a sticky overflow flag and, when the
//               WPTR_FULL_AFULL_EN macro is defined, almost-full and
//               fill-level outputs.
// Ports       : wclk      in  1            write clock
//               wrst_n    in  1            async active-low reset
//               winc      in  1            write request
//               wq2_rptr  in  ADDR_SIZE+1  synchronized Gray read pointer
//               wovf_clr  in  1            clears woverflow
//               wfull     out 1            registered full flag
//               waddr     out ADDR_SIZE    memory write address
//               wptr      out ADDR_SIZE+1  registered Gray write pointer
//               woverflow out 1            sticky write-while-full flag
//               wafull    out 1            almost-full (0 without macro)
//               wcount    out ADDR_SIZE+1  fill level (0 without macro)
// Macro       : WPTR_FULL_AFULL_EN enables wafull/wcount logic.
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = FIFO_ADDR_SIZE,
  parameter int AFULL_LEVEL = 2**ADDR_SIZE - 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic                 wovf_clr,
  output logic                 wfull,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 woverflow,
  output logic                 wafull,
  output logic [ADDR_SIZE:0]   wcount
);

  localparam int PTR_W = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbinnext;
  logic [ADDR_SIZE:0] wgraynext;
  logic               wfull_val;
  logic               winc_ok;

  assign winc_ok   = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDR_SIZE{1'b0}}, winc_ok};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Full when the next write pointer has lapped the read pointer once: in
  // Gray code that means the top two bits differ and the rest match.
  assign wfull_val = (wgraynext == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                                    wq2_rptr[ADDR_SIZE-2:0]});

  assign waddr = wbin[ADDR_SIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin  <= wbinnext;
      wptr  <= wgraynext;
      wfull <= wfull_val;
      // Set has priority so a rejected write is never hidden by a clear.
      if (winc & wfull)
        woverflow <= 1'b1;
      else if (wovf_clr)
        woverflow <= 1'b0;
    end
  end

`ifdef WPTR_FULL_AFULL_EN
  localparam logic [ADDR_SIZE:0] AFULL_THR = AFULL_LEVEL[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] rbin_sync;
  logic [ADDR_SIZE:0] wlvl;

  gray2bin #(.W(PTR_W)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_sync)
  );

  // Modulo subtraction gives 0..2**ADDR_SIZE because the pointers never
  // drift apart by more than one lap.
  assign wlvl = wbinnext - rbin_sync;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wcount <= '0;
      wafull <= 1'b0;
    end else begin
      wcount <= wlvl;
      wafull <= (wlvl >= AFULL_THR);
    end
  end
`else
  logic unused_afull_level;

  assign unused_afull_level = (AFULL_LEVEL > PTR_W);
  assign wcount = '0;
  assign wafull = 1'b0;
`endif

endmodule
`default_nettype wire
